// File: rtl/usr_seq_pkg.sv
// Shared types for the command sequencer: shift-register op codes,
// sequencer FSM states and the width of the optional issue counter.
package usr_seq_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_SHL  = 2'b01,
    OP_SHR  = 2'b10,
    OP_LOAD = 2'b11
  } op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int ISSUED_W = 16;

  // A command produces issue cycles unless it is a shift/hold with a zero count
  function automatic logic op_issues(input op_e op, input logic nonzero_cnt);
    return (op == OP_LOAD) || nonzero_cnt;
  endfunction

endpackage

// File: rtl/univ_shift_reg.sv
// Universal shift register fed by the sequencer. Shifts take their
// serial-in bit from d: d[0] enters on a left shift, d[N-1] on a right shift.
module univ_shift_reg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   ctrl,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  // Register update selected by ctrl: hold, shift left, shift right, load
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      case (ctrl)
        2'b01:   q <= {q[N-2:0], d[0]};
        2'b10:   q <= {d[N-1], q[N-1:1]};
        2'b11:   q <= d;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/usr_cmd_fifo.sv
// Command FIFO for the sequencer. Pointers carry one extra wrap bit so
// full and empty can be told apart when the index bits are equal.
module usr_cmd_fifo
  import usr_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; both wrap naturally modulo 2*DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset since empty gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/usr_cmd_sequencer.sv
// Command sequencer driving a universal shift register. Commands are
// queued in a FIFO and replayed as ctrl/d cycles: a load issues once,
// a shift or hold issues for its repeat count, and consecutive commands
// follow each other without a bubble.
// Optional build macro USR_SEQ_STATUS_EN adds the issued_cnt status output.
module usr_cmd_sequencer
  import usr_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int CNT_W = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [N-1:0]     in_data,
  input  logic [CNT_W-1:0] in_cnt,
  output logic [1:0]       ctrl,
  output logic [N-1:0]     d,
  output logic             busy,
  output logic             done
`ifdef USR_SEQ_STATUS_EN
  ,
  output logic [ISSUED_W-1:0] issued_cnt
`endif
);

  localparam int CMD_W = 2 + N + CNT_W;

  logic [CMD_W-1:0] wr_cmd;
  logic [CMD_W-1:0] head_cmd;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;

  op_e              head_op;
  logic [N-1:0]     head_data;
  logic [CNT_W-1:0] head_cnt;
  logic [CNT_W-1:0] head_len;
  logic             head_issues;

  state_e           state;
  state_e           next_state;
  op_e              cur_op;
  logic [N-1:0]     cur_data;
  logic [CNT_W-1:0] remaining;
  logic             load_cur;

  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  assign wr_cmd   = {in_op, in_data, in_cnt};

  assign head_op     = op_e'(head_cmd[CMD_W-1 -: 2]);
  assign head_data   = head_cmd[CNT_W +: N];
  assign head_cnt    = head_cmd[CNT_W-1:0];
  assign head_issues = op_issues(head_op, head_cnt != '0);
  assign head_len    = (head_op == OP_LOAD) ? CNT_W'(1) : head_cnt;

  assign busy = (state == ST_RUN) || !fifo_empty;

  usr_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (wr_cmd),
    .pop     (pop),
    .rd_data (head_cmd),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // Next state, FIFO pop and issue outputs; the head is fetched in IDLE or on the last RUN cycle
  always_comb begin
    next_state = state;
    pop        = 1'b0;
    load_cur   = 1'b0;
    ctrl       = 2'b00;
    d          = '0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_issues) begin
            load_cur   = 1'b1;
            next_state = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        ctrl = cur_op;
        d    = cur_data;
        if (remaining == CNT_W'(1)) begin
          done       = 1'b1;
          next_state = ST_IDLE;
          if (!fifo_empty) begin
            pop = 1'b1;
            if (head_issues) begin
              load_cur   = 1'b1;
              next_state = ST_RUN;
            end
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Current command register and remaining issue count
  always_ff @(posedge clk) begin
    if (reset) begin
      cur_op    <= OP_HOLD;
      cur_data  <= '0;
      remaining <= '0;
    end else if (load_cur) begin
      cur_op    <= head_op;
      cur_data  <= head_data;
      remaining <= head_len;
    end else if (state == ST_RUN) begin
      remaining <= remaining - CNT_W'(1);
    end
  end

`ifdef USR_SEQ_STATUS_EN
  // Saturating count of RUN cycles that actually move the register
  always_ff @(posedge clk) begin
    if (reset) begin
      issued_cnt <= '0;
    end else if ((state == ST_RUN) && (ctrl != 2'b00) && (issued_cnt != '1)) begin
      issued_cnt <= issued_cnt + 1'b1;
    end
  end
`else
  // Status counter is not built in this configuration
`endif

endmodule

// File: tb/tb_usr_cmd_sequencer.sv
// Directed bench: sequencer driving a 4-bit universal shift register.
module tb_usr_cmd_sequencer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [3:0] in_data;
  logic [3:0] in_cnt;
  logic [1:0] ctrl;
  logic [3:0] d;
  logic       busy;
  logic       done;
  logic [3:0] q;
`ifdef USR_SEQ_STATUS_EN
  logic [15:0] issued_cnt;
`endif

  int checks = 0;
  int passed = 0;

  usr_cmd_sequencer #(.N(4), .CNT_W(4), .DEPTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_data  (in_data),
    .in_cnt   (in_cnt),
    .ctrl     (ctrl),
    .d        (d),
    .busy     (busy),
    .done     (done)
`ifdef USR_SEQ_STATUS_EN
    ,
    .issued_cnt (issued_cnt)
`endif
  );

  univ_shift_reg #(.N(4)) u_sr (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ctrl),
    .d     (d),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [1:0] op, input logic [3:0] data, input logic [3:0] cnt);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = data;
    in_cnt   = cnt;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    in_valid = 1'b1;
    in_op    = 2'b11;
    in_data  = 4'b0110;
    in_cnt   = 4'd0;
    tick();
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    checks++; if (ctrl !== 2'b00) $display("[TB] FAIL reset_ctrl: got %b expected 00", ctrl); else passed++;
    checks++; if (d !== 4'b0000) $display("[TB] FAIL reset_d: got %b expected 0000", d); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passed++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passed++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); else passed++;
`ifdef USR_SEQ_STATUS_EN
    checks++; if (issued_cnt !== 16'd0) $display("[TB] FAIL reset_issued: got %0d expected 0", issued_cnt); else passed++;
`endif
    tick();
    tick();
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_ignores_valid: busy got %b expected 0", busy); else passed++;
    checks++; if (q !== 4'b0000) $display("[TB] FAIL reset_q: got %b expected 0000", q); else passed++;
  endtask

  task automatic test_load();
    push_one(2'b11, 4'b1010, 4'd0);
    checks++; if (ctrl !== 2'b00 || busy !== 1'b1) $display("[TB] FAIL load_queued: ctrl/busy got %b/%b expected 00/1", ctrl, busy); else passed++;
    tick();
    checks++; if (ctrl !== 2'b11) $display("[TB] FAIL load_ctrl: got %b expected 11", ctrl); else passed++;
    checks++; if (d !== 4'b1010) $display("[TB] FAIL load_d: got %b expected 1010", d); else passed++;
    checks++; if (done !== 1'b1) $display("[TB] FAIL load_done: got %b expected 1", done); else passed++;
    tick();
    checks++; if (q !== 4'b1010) $display("[TB] FAIL load_q: got %b expected 1010", q); else passed++;
    checks++; if (ctrl !== 2'b00 || done !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL load_idle: ctrl/done/busy got %b/%b/%b expected 00/0/0", ctrl, done, busy); else passed++;
  endtask

  task automatic test_shl();
    logic [1:0] exp_ctrl [4] = '{2'b01, 2'b01, 2'b01, 2'b00};
    logic       exp_done [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] exp_q    [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    push_one(2'b11, 4'b0001, 4'd0);
    tick();
    tick();
    checks++; if (q !== 4'b0001) $display("[TB] FAIL shl_preload_q: got %b expected 0001", q); else passed++;
    push_one(2'b01, 4'b0000, 4'd3);
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (ctrl !== exp_ctrl[k]) $display("[TB] FAIL shl_ctrl[%0d]: got %b expected %b", k, ctrl, exp_ctrl[k]); else passed++;
      checks++; if (done !== exp_done[k]) $display("[TB] FAIL shl_done[%0d]: got %b expected %b", k, done, exp_done[k]); else passed++;
      checks++; if (q !== exp_q[k]) $display("[TB] FAIL shl_q[%0d]: got %b expected %b", k, q, exp_q[k]); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_ctrl [5] = '{2'b11, 2'b10, 2'b10, 2'b00, 2'b00};
    logic [3:0] exp_d    [5] = '{4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic       exp_done [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int dcount = 0;
    push_one(2'b11, 4'b1111, 4'd0);
    for (int k = 0; k < 5; k++) begin
      in_valid = (k < 2);
      in_op    = (k == 0) ? 2'b10 : 2'b00;
      in_data  = 4'b0000;
      in_cnt   = 4'd2;
      tick();
      if (done === 1'b1) dcount++;
      checks++; if (ctrl !== exp_ctrl[k]) $display("[TB] FAIL b2b_ctrl[%0d]: got %b expected %b", k, ctrl, exp_ctrl[k]); else passed++;
      checks++; if (d !== exp_d[k]) $display("[TB] FAIL b2b_d[%0d]: got %b expected %b", k, d, exp_d[k]); else passed++;
      checks++; if (done !== exp_done[k] || busy !== 1'b1) $display("[TB] FAIL b2b_done_busy[%0d]: got %b/%b expected %b/1", k, done, busy, exp_done[k]); else passed++;
    end
    in_valid = 1'b0;
    tick();
    checks++; if (q !== 4'b0011) $display("[TB] FAIL b2b_q: got %b expected 0011", q); else passed++;
    checks++; if (dcount != 3) $display("[TB] FAIL b2b_done_count: got %0d expected 3", dcount); else passed++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL b2b_busy_end: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_stall();
    logic [1:0] s_op   [6] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    logic [3:0] s_data [6] = '{4'b0000, 4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1100};
    logic [3:0] s_cnt  [6] = '{4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    int exp_acc [6] = '{0, 1, 2, 3, 4, 7};
    logic [3:0] exp_ld [5] = '{4'b0011, 4'b0101, 4'b0110, 4'b1001, 4'b1100};
    int acc_tick [6] = '{-1, -1, -1, -1, -1, -1};
    logic [3:0] issued_d [$];
    int next_cmd = 0;
    int shl_cycles = 0;
    logic ready_after_fill = 1'bx;
    logic fire;
    for (int i = 0; i < 30; i++) begin
      if (next_cmd < 6) begin
        in_valid = 1'b1;
        in_op    = s_op[next_cmd];
        in_data  = s_data[next_cmd];
        in_cnt   = s_cnt[next_cmd];
      end else begin
        in_valid = 1'b0;
      end
      fire = in_valid && in_ready;
      tick();
      if (fire) begin
        acc_tick[next_cmd] = i;
        next_cmd++;
        if (next_cmd == 5) ready_after_fill = in_ready;
      end
      if (ctrl == 2'b11) issued_d.push_back(d);
      if (ctrl == 2'b01) shl_cycles++;
    end
    in_valid = 1'b0;
    checks++; if (ready_after_fill !== 1'b0) $display("[TB] FAIL stall_full_ready: got %b expected 0", ready_after_fill); else passed++;
    for (int k = 0; k < 6; k++) begin
      checks++; if (acc_tick[k] != exp_acc[k]) $display("[TB] FAIL stall_accept[%0d]: got tick %0d expected tick %0d", k, acc_tick[k], exp_acc[k]); else passed++;
    end
    checks++; if (shl_cycles != 5) $display("[TB] FAIL stall_shl_cycles: got %0d expected 5", shl_cycles); else passed++;
    checks++;
    if (issued_d.size() != 5) begin
      $display("[TB] FAIL stall_issue_count: got %0d expected 5", issued_d.size());
    end else begin
      passed++;
      for (int k = 0; k < 5; k++) begin
        checks++; if (issued_d[k] !== exp_ld[k]) $display("[TB] FAIL stall_order[%0d]: got %b expected %b", k, issued_d[k], exp_ld[k]); else passed++;
      end
    end
    checks++; if (q !== 4'b1100) $display("[TB] FAIL stall_q: got %b expected 1100", q); else passed++;
  endtask

  task automatic test_zero_cnt();
    push_one(2'b01, 4'b1111, 4'd0);
    checks++; if (busy !== 1'b1) $display("[TB] FAIL zero_busy_queued: got %b expected 1", busy); else passed++;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (ctrl !== 2'b00 || done !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL zero_retire[%0d]: ctrl/done/busy got %b/%b/%b expected 00/0/0", k, ctrl, done, busy); else passed++;
    end
    checks++; if (q !== 4'b1100) $display("[TB] FAIL zero_q: got %b expected 1100", q); else passed++;
  endtask

  task automatic test_reset_abort();
    push_one(2'b10, 4'b0000, 4'd5);
    in_valid = 1'b1;
    in_op    = 2'b11;
    in_data  = 4'b0101;
    in_cnt   = 4'd0;
    tick();
    checks++; if (ctrl !== 2'b10) $display("[TB] FAIL abort_first_cycle: got %b expected 10", ctrl); else passed++;
    in_data = 4'b1010;
    tick();
    in_valid = 1'b0;
    checks++; if (ctrl !== 2'b10 || busy !== 1'b1) $display("[TB] FAIL abort_second_cycle: ctrl/busy got %b/%b expected 10/1", ctrl, busy); else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (ctrl !== 2'b00 || d !== 4'b0000) $display("[TB] FAIL abort_outputs: ctrl/d got %b/%b expected 00/0000", ctrl, d); else passed++;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) $display("[TB] FAIL abort_status: busy/done/ready got %b/%b/%b expected 0/0/1", busy, done, in_ready); else passed++;
`ifdef USR_SEQ_STATUS_EN
    checks++; if (issued_cnt !== 16'd0) $display("[TB] FAIL abort_issued: got %0d expected 0", issued_cnt); else passed++;
`endif
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++; if (ctrl !== 2'b00 || done !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL abort_quiet[%0d]: ctrl/done/busy got %b/%b/%b expected 00/0/0", k, ctrl, done, busy); else passed++;
    end
    checks++; if (q !== 4'b0000) $display("[TB] FAIL abort_q: got %b expected 0000", q); else passed++;
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_op    = 2'b00;
    in_data  = 4'b0000;
    in_cnt   = 4'd0;
    test_reset();
    test_load();
    test_shl();
    test_back_to_back();
    test_stall();
    test_zero_cnt();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
